// File: rtl/lopd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lopd_pkg
//  Description : Shared defaults for the LOPD normalizer arbiter: mantissa,
//                leading-one position and exponent widths, and the FSM state
//                encoding used by lopd_norm_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package lopd_pkg;

    localparam int c_SIZE_DATA = 24;
    localparam int c_SIZE_LOPD = 5;
    localparam int c_SIZE_EXP  = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DETECT = 2'd1,
        S_SHIFT  = 2'd2,
        S_OUT    = 2'd3
    } state_t;

endpackage : lopd_pkg
`default_nettype wire

// File: rtl/Question2.sv
`default_nettype none
// ============================================================================
//  Module      : Question2
//  Description : Leading-one position detector. Reports the bit index of the
//                most significant set bit of i_data and flags an all-zero
//                word (o_pos is 0 in that case).
//  Ports       : i_data [SIZE_DATA] - word to scan
//                o_pos  [SIZE_LOPD] - index of the highest set bit
//                o_zero             - i_data is all zeros
//  Revision    : 1.0 - initial release
// ============================================================================
module Question2 #(
    parameter int SIZE_DATA = 24,
    parameter int SIZE_LOPD = 5
) (
    input  logic [SIZE_DATA-1:0] i_data,
    output logic [SIZE_LOPD-1:0] o_pos,
    output logic                 o_zero
);

    // Upward scan: the last set bit seen is the most significant one.
    always_comb begin
        o_pos = '0;
        for (int i = 0; i < SIZE_DATA; i++) begin
            if (i_data[i]) begin
                o_pos = SIZE_LOPD'(i);
            end
        end
    end

    assign o_zero = ~|i_data;

endmodule : Question2
`default_nettype wire

// File: rtl/lopd_norm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lopd_norm_arbiter
//  Description : Two-requester round-robin front end for a floating-point
//                normalizer. An accepted operand walks IDLE -> DETECT ->
//                SHIFT -> OUT: its leading one is located by the shared
//                Question2 detector, the mantissa is shifted left so the
//                MSB is set and the exponent is reduced by the same amount,
//                clamping at 0 (underflow) when the exponent is too small.
//  Ports       : i_clk, i_rst            - clock, sync active-high reset
//                i_a_* / i_b_*           - requester valid/mant/exp
//                o_a_ready / o_b_ready   - operand accepted this cycle
//                o_valid / i_ready       - result handshake
//                o_mant, o_exp           - normalized mantissa / exponent
//                o_zero_flag, o_underflow, o_src - result status, source
//  Revision    : 1.0 - initial release
// ============================================================================
module lopd_norm_arbiter
    import lopd_pkg::*;
#(
    parameter int SIZE_DATA = c_SIZE_DATA,
    parameter int SIZE_LOPD = c_SIZE_LOPD,
    parameter int SIZE_EXP  = c_SIZE_EXP
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_a_valid,
    input  logic                 i_b_valid,
    output logic                 o_a_ready,
    output logic                 o_b_ready,
    input  logic [SIZE_DATA-1:0] i_a_mant,
    input  logic [SIZE_DATA-1:0] i_b_mant,
    input  logic [SIZE_EXP-1:0]  i_a_exp,
    input  logic [SIZE_EXP-1:0]  i_b_exp,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_mant,
    output logic [SIZE_EXP-1:0]  o_exp,
    output logic                 o_zero_flag,
    output logic                 o_underflow,
    output logic                 o_src
);

    // Common width for comparing/subtracting the exponent and shift amount.
    localparam int c_CW = (SIZE_EXP > SIZE_LOPD) ? SIZE_EXP : SIZE_LOPD;

    state_t                r_state;
    logic                  r_prio;      // 0 = A has priority, 1 = B
    logic [SIZE_DATA-1:0]  r_mant;
    logic [SIZE_EXP-1:0]   r_exp;
    logic                  r_src;
    logic [SIZE_LOPD-1:0]  r_pos;
    logic                  r_zero;

    logic                  r_out_valid;
    logic [SIZE_DATA-1:0]  r_out_mant;
    logic [SIZE_EXP-1:0]   r_out_exp;
    logic                  r_out_zero;
    logic                  r_out_uf;
    logic                  r_out_src;

    logic                  w_grant_a;
    logic                  w_grant_b;
    logic                  w_idle;
    logic                  w_accept;
    logic [SIZE_LOPD-1:0]  w_pos;
    logic                  w_zero;
    logic [SIZE_LOPD-1:0]  w_amt;
    logic [c_CW-1:0]       w_exp_ext;
    logic [c_CW-1:0]       w_amt_ext;
    logic [c_CW-1:0]       w_exp_diff;
    logic                  w_no_uf;

    // Pointer holder wins if valid; otherwise the other requester may go.
    assign w_grant_a = i_a_valid & (~r_prio | ~i_b_valid);
    assign w_grant_b = i_b_valid & ( r_prio | ~i_a_valid);

    assign w_idle    = (r_state == S_IDLE) & ~i_rst;
    assign o_a_ready = w_idle & w_grant_a;
    assign o_b_ready = w_idle & w_grant_b;
    assign w_accept  = o_a_ready | o_b_ready;

    // Single detector, fed from the captured operand so both requesters share it.
    Question2 #(
        .SIZE_DATA (SIZE_DATA),
        .SIZE_LOPD (SIZE_LOPD)
    ) u_lopd (
        .i_data (r_mant),
        .o_pos  (w_pos),
        .o_zero (w_zero)
    );

    assign w_amt      = SIZE_LOPD'(SIZE_DATA - 1) - r_pos;
    assign w_exp_ext  = c_CW'(r_exp);
    assign w_amt_ext  = c_CW'(w_amt);
    assign w_no_uf    = (w_exp_ext >= w_amt_ext);
    assign w_exp_diff = w_exp_ext - w_amt_ext;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_prio      <= 1'b0;
            r_mant      <= '0;
            r_exp       <= '0;
            r_src       <= 1'b0;
            r_pos       <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_mant  <= '0;
            r_out_exp   <= '0;
            r_out_zero  <= 1'b0;
            r_out_uf    <= 1'b0;
            r_out_src   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mant  <= o_b_ready ? i_b_mant : i_a_mant;
                        r_exp   <= o_b_ready ? i_b_exp  : i_a_exp;
                        r_src   <= o_b_ready;
                        r_state <= S_DETECT;
                    end
                end
                S_DETECT: begin
                    r_pos   <= w_pos;
                    r_zero  <= w_zero;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_zero) begin
                        r_out_mant <= '0;
                        r_out_exp  <= '0;
                        r_out_zero <= 1'b1;
                        r_out_uf   <= 1'b0;
                    end else if (w_no_uf) begin
                        r_out_mant <= r_mant << w_amt;
                        r_out_exp  <= w_exp_diff[SIZE_EXP-1:0];
                        r_out_zero <= 1'b0;
                        r_out_uf   <= 1'b0;
                    end else begin
                        // Exponent exhausted: shift only as far as it allows.
                        r_out_mant <= r_mant << r_exp;
                        r_out_exp  <= '0;
                        r_out_zero <= 1'b0;
                        r_out_uf   <= 1'b1;
                    end
                    r_out_src   <= r_src;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (i_ready) begin
                        r_out_valid <= 1'b0;
                        r_prio      <= ~r_out_src;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_valid     = r_out_valid;
    assign o_mant      = r_out_mant;
    assign o_exp       = r_out_exp;
    assign o_zero_flag = r_out_zero;
    assign o_underflow = r_out_uf;
    assign o_src       = r_out_src;

endmodule : lopd_norm_arbiter
`default_nettype wire

// File: tb/tb_lopd_norm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lopd_norm_arbiter
//  Description : Self-checking bench for lopd_norm_arbiter: directed
//                scenarios plus randomized operands against a behavioural
//                normalization model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lopd_norm_arbiter;

    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  exp;
        logic        zero;
        logic        uf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [23:0] a_mant, b_mant;
    logic [7:0]  a_exp, b_exp;
    logic        o_valid, rdy;
    logic [23:0] o_mant;
    logic [7:0]  o_exp;
    logic        o_zero, o_uf, o_src;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lopd_norm_arbiter #(
        .SIZE_DATA (24),
        .SIZE_LOPD (5),
        .SIZE_EXP  (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_a_valid   (a_valid),
        .i_b_valid   (b_valid),
        .o_a_ready   (a_ready),
        .o_b_ready   (b_ready),
        .i_a_mant    (a_mant),
        .i_b_mant    (b_mant),
        .i_a_exp     (a_exp),
        .i_b_exp     (b_exp),
        .o_valid     (o_valid),
        .i_ready     (rdy),
        .o_mant      (o_mant),
        .o_exp       (o_exp),
        .o_zero_flag (o_zero),
        .o_underflow (o_uf),
        .o_src       (o_src)
    );

    // Normalization rule: shift until bit 23 is set, paying one exponent
    // unit per position; stop early (underflow) if the exponent runs out.
    function automatic res_t model(input logic [23:0] m, input logic [7:0] e);
        res_t r;
        int   v, p, amt, ei;
        r  = '0;
        ei = int'(e);
        if (m == 24'd0) begin
            r.zero = 1'b1;
        end else begin
            v = int'(m);
            p = 0;
            while (v > 1) begin
                v = v / 2;
                p = p + 1;
            end
            amt = 23 - p;
            if (ei >= amt) begin
                r.mant = 24'((int'(m) * (1 << amt)) & 32'h00FF_FFFF);
                r.exp  = 8'(ei - amt);
            end else begin
                r.mant = 24'((int'(m) * (1 << ei)) & 32'h00FF_FFFF);
                r.uf   = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input res_t e, input logic esrc);
        check({tag, "_mant"}, 32'(o_mant), 32'(e.mant));
        check({tag, "_exp"},  32'(o_exp),  32'(e.exp));
        check({tag, "_zero"}, 32'(o_zero), 32'(e.zero));
        check({tag, "_uf"},   32'(o_uf),   32'(e.uf));
        check({tag, "_src"},  32'(o_src),  32'(esrc));
    endtask

    // One operand from a single requester; result held for 'hold' cycles.
    task automatic run_one(input string tag, input logic src, input logic [23:0] m,
                           input logic [7:0] e, input int hold);
        res_t exp_r;
        int   cnt;
        exp_r   = model(m, e);
        a_valid = ~src;
        b_valid = src;
        a_mant  = m;
        b_mant  = m;
        a_exp   = e;
        b_exp   = e;
        rdy     = 1'b0;
        #1;
        cnt = 0;
        while (!(src ? b_ready : a_ready) && cnt < 20) begin
            tick();
            cnt++;
        end
        check({tag, "_granted"}, 32'(src ? b_ready : a_ready), 32'd1);
        check({tag, "_other_rdy"}, 32'(src ? a_ready : b_ready), 32'd0);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        check({tag, "_lat1"}, 32'(o_valid), 32'd0);
        tick();
        check({tag, "_lat2"}, 32'(o_valid), 32'd0);
        tick();
        check({tag, "_lat3"}, 32'(o_valid), 32'd1);
        check_res(tag, exp_r, src);
        for (int h = 0; h < hold; h++) begin
            a_valid = 1'b1;
            b_valid = 1'b1;
            tick();
            check({tag, "_hold_valid"}, 32'(o_valid), 32'd1);
            check({tag, "_hold_rdys"}, 32'({a_ready, b_ready}), 32'd0);
            check_res({tag, "_hold"}, exp_r, src);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        rdy     = 1'b1;
        tick();
        check({tag, "_done"}, 32'(o_valid), 32'd0);
        rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t        ra, rb, er;
        logic [23:0] ma, mb, m;
        logic [7:0]  ea, eb, e;
        logic        s;
        logic        srcs[$];
        int          both_hi, cnt, sh, quiet;

        // Reset: outputs cleared, readies held low even with valid requests.
        rst = 1'b1; rdy = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        a_mant = 24'h123456; b_mant = 24'h654321; a_exp = 8'd9; b_exp = 8'd9;
        tick(); tick();
        check("rst_rdys", 32'({a_ready, b_ready}), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check_res("rst", '0, 1'b0);
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Directed cases.
        run_one("a_one",   1'b0, 24'h000001, 8'd30, 0);
        run_one("b_zero",  1'b1, 24'h000000, 8'd50, 0);
        run_one("a_uf",    1'b0, 24'h000010, 8'd5,  0);
        run_one("a_eq",    1'b0, 24'h000010, 8'd19, 0);
        run_one("a_msb",   1'b0, 24'h800000, 8'd0,  0);
        run_one("b_hold",  1'b1, 24'h0ABCDE, 8'd200, 5);

        // Randomized operands, leading-one position spread by a random shift.
        for (int t = 0; t < 24; t++) begin
            s  = 1'($urandom_range(0, 1));
            sh = int'($urandom_range(0, 24));
            m  = (sh == 24) ? 24'd0 : (24'($urandom) >> sh);
            e  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 30))
                                             : 8'($urandom_range(0, 255));
            run_one($sformatf("rand%0d", t), s, m, e, int'($urandom_range(0, 2)));
        end

        // Round-robin: both requesters valid from reset.
        ma = 24'h000F00; ea = 8'd40;
        mb = 24'h3000AA; eb = 8'd1;
        ra = model(ma, ea);
        rb = model(mb, eb);
        rst = 1'b1; rdy = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        a_mant = ma; a_exp = ea; b_mant = mb; b_exp = eb;
        tick(); tick();
        rst = 1'b0;
        #1;
        both_hi = 0;
        cnt     = 0;
        while (srcs.size() < 4 && cnt < 60) begin
            if (a_ready && b_ready) both_hi++;
            if (o_valid) begin
                srcs.push_back(o_src);
                check_res($sformatf("rr%0d", srcs.size()), o_src ? rb : ra, o_src);
            end
            tick();
            cnt++;
        end
        check("rr_count", 32'(srcs.size()), 32'd4);
        check("rr_both_ready", 32'(both_hi), 32'd0);
        if (srcs.size() == 4) begin
            check("rr_order", 32'({srcs[0], srcs[1], srcs[2], srcs[3]}), 32'b0101);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; rdy = 1'b0;
        tick();

        // Reset while the operand sits in SHIFT: it must be dropped.
        run_one("pre_rst", 1'b1, 24'h00F0F0, 8'd100, 0);
        a_valid = 1'b1; a_mant = 24'h001234; a_exp = 8'd100;
        #1;
        check("mid_accept", 32'(a_ready), 32'd1);
        tick();                 // DETECT
        a_valid = 1'b0;
        tick();                 // SHIFT
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check_res("mid_rst", '0, 1'b0);
        rst = 1'b0;
        quiet = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (o_valid) quiet++;
        end
        check("mid_rst_no_result", 32'(quiet), 32'd0);
        run_one("post_rst", 1'b0, 24'h001234, 8'd100, 1);

        er = model(24'h000003, 8'd2);
        run_one("b_small_uf", 1'b1, 24'h000003, 8'd2, 0);
        check("model_uf_sanity_exp", 32'(o_exp), 32'(er.exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_lopd_norm_arbiter
`default_nettype wire
